spi_therm_responder: RTL and testbench

SPI_THERM_RESPONDER -- requirements
Module: spi_therm_responder

---
 rtl/thermostat_spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_therm_responder.sv | 211 +++++++++++++++++++++
 tb/tb_spi_therm_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/thermostat_spi_pkg.sv
// Shared types and constants for the SPI temperature responder.
package thermostat_spi_pkg;

   localparam int C_CMD_W   = 8;
   localparam int C_FRAME_W = 16;
   localparam int C_TEMP_W  = 10;

   // Command byte that asks for the current temperature.
   localparam logic [C_CMD_W-1:0] C_CMD_READ = 8'h03;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_RESP  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Response frame: temperature right-aligned, upper bits zero.
   function automatic logic [C_FRAME_W-1:0] build_frame(input logic [C_TEMP_W-1:0] temp);
      return {{(C_FRAME_W - C_TEMP_W){1'b0}}, temp};
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, with one-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
   parameter int   G_STAGES = 2,
   parameter logic G_IDLE   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [G_STAGES-1:0] chain;
   logic                prev;

   // Synchronizer chain plus one delayed copy for edge detection.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
      if (reset) begin
         chain <= {G_STAGES{G_IDLE}};
         prev  <= G_IDLE;
      end else begin
         chain <= {chain[G_STAGES-2:0], din};
         prev  <= chain[G_STAGES-1];
      end
   end

   assign level = chain[G_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_therm_responder.sv
// SPI mode-0 responder: receives a command byte and, for a READ command,
// returns a 16-bit snapshot of the live temperature.
module spi_therm_responder
   import thermostat_spi_pkg::*;
#(
   parameter logic [C_CMD_W-1:0] G_CMD_READ    = C_CMD_READ,
   parameter int                 G_SYNC_STAGES = 2
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [C_TEMP_W-1:0] i_temperature,
   input  logic                i_spi_clk,
   input  logic                i_spi_cs_n,
   input  logic                i_spi_si,
   output logic                o_spi_so,
   output logic                o_spi_so_en,
   output logic [C_CMD_W-1:0]  o_cmd,
   output logic                o_cmd_valid,
   output logic                o_bad_cmd,
   output logic                o_done,
   output logic                o_busy
);

   logic sck_level, sck_rise, sck_fall;
   logic cs_level, cs_rise, cs_fall;
   logic unused_sck_level;

   spi_sync_edge #(.G_STAGES(G_SYNC_STAGES), .G_IDLE(1'b0)) u_sck_sync (
      .clk   (i_clk),
      .reset (i_reset),
      .din   (i_spi_clk),
      .level (sck_level),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   spi_sync_edge #(.G_STAGES(G_SYNC_STAGES), .G_IDLE(1'b1)) u_cs_sync (
      .clk   (i_clk),
      .reset (i_reset),
      .din   (i_spi_cs_n),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   // SCK level is not needed; all SPI timing comes from its edges.
   assign unused_sck_level = sck_level;

   logic [G_SYNC_STAGES-1:0] si_chain;
   logic [G_SYNC_STAGES-1:0] settle;
   logic                     si_sync;
   logic                     armed;

   // SI synchronizer and start-up arming: a CS_n falling edge is accepted only
   // after CS_n has been seen high with the synchronizers refilled, so a chip
   // select still held low across a reset cannot start a frame.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         si_chain <= '0;
         settle   <= '0;
         armed    <= 1'b0;
      end else begin
         si_chain <= {si_chain[G_SYNC_STAGES-2:0], i_spi_si};
         settle   <= {settle[G_SYNC_STAGES-2:0], 1'b1};
         if (settle[G_SYNC_STAGES-1] && cs_level) begin
            armed <= 1'b1;
         end
      end
   end

   assign si_sync = si_chain[G_SYNC_STAGES-1];

   state_t                 state_q, state_d;
   logic [3:0]             bit_cnt;
   logic [C_CMD_W-1:0]     shift_q;
   logic [C_CMD_W-1:0]     cmd_next;
   logic [C_FRAME_W-1:0]   frame_q;
   logic                   so_q;
   logic [C_CMD_W-1:0]     cmd_q;
   logic                   cmd_valid_q, bad_q, done_q;

   logic start, cnt_clr, cnt_inc, shift_en, cmd_load;
   logic frame_load, frame_shift, bad_d, done_d;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign cmd_next = {shift_q[C_CMD_W-2:0], si_sync};

   // Next-state and datapath controls; CS_n rising overrides everything.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d     = state_q;
      start       = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      shift_en    = 1'b0;
      cmd_load    = 1'b0;
      frame_load  = 1'b0;
      frame_shift = 1'b0;
      bad_d       = 1'b0;
      done_d      = 1'b0;
      if (cs_rise) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cs_fall && armed) begin
                  state_d = ST_CMD;
                  start   = 1'b1;
                  cnt_clr = 1'b1;
               end
            end
            ST_CMD: begin
               if (sck_rise) begin
                  shift_en = 1'b1;
                  cnt_inc  = 1'b1;
                  if (bit_cnt == 4'd7) begin
                     cmd_load = 1'b1;
                     cnt_clr  = 1'b1;
                     if (cmd_next == G_CMD_READ) begin
                        state_d    = ST_RESP;
                        frame_load = 1'b1;
                     end else begin
                        bad_d   = 1'b1;
                        state_d = ST_DRAIN;
                     end
                  end
               end
            end
            ST_RESP: begin
               frame_shift = sck_fall;
               if (sck_rise) begin
                  cnt_inc = 1'b1;
                  if (bit_cnt == 4'd15) begin
                     done_d  = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               state_d = ST_DRAIN;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Bit counter, command shifter, response frame and status pulses.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bit_cnt     <= '0;
         shift_q     <= '0;
         frame_q     <= '0;
         so_q        <= 1'b0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         bad_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cmd_valid_q <= cmd_load;
         bad_q       <= bad_d;
         done_q      <= done_d;

         if (cnt_clr) begin
            bit_cnt <= '0;
         end else if (cnt_inc) begin
            bit_cnt <= bit_cnt + 4'd1;
         end

         if (start) begin
            shift_q <= '0;
         end else if (shift_en) begin
            shift_q <= cmd_next;
         end

         if (cmd_load) begin
            cmd_q <= cmd_next;
         end

         // The frame is captured once, on the 8th command bit, and only shifted
         // afterwards, so temperature changes mid-frame cannot tear the reply.
         if (frame_load) begin
            frame_q <= build_frame(i_temperature);
            so_q    <= 1'b0;
         end else if (frame_shift) begin
            so_q    <= frame_q[C_FRAME_W-1];
            frame_q <= {frame_q[C_FRAME_W-2:0], 1'b0};
         end else if (state_d != ST_RESP) begin
            so_q <= 1'b0;
         end
      end
   end

   assign o_spi_so_en = (state_q == ST_RESP);
   assign o_spi_so    = o_spi_so_en & so_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_cmd       = cmd_q;
   assign o_cmd_valid = cmd_valid_q;
   assign o_bad_cmd   = bad_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_spi_therm_responder.sv
// Self-checking bench: acts as an SPI mode-0 initiator, compares captured
// replies and pulse counts against a frame-level model, and monitors
// output invariants every cycle.
`timescale 1ns/1ps
module tb_spi_therm_responder;

   localparam int HALF = 8;  // system clocks per SCK half period

   logic       i_clk;
   logic       i_reset;
   logic [9:0] i_temperature;
   logic       i_spi_clk;
   logic       i_spi_cs_n;
   logic       i_spi_si;
   logic       o_spi_so;
   logic       o_spi_so_en;
   logic [7:0] o_cmd;
   logic       o_cmd_valid;
   logic       o_bad_cmd;
   logic       o_done;
   logic       o_busy;

   spi_therm_responder dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_temperature (i_temperature),
      .i_spi_clk     (i_spi_clk),
      .i_spi_cs_n    (i_spi_cs_n),
      .i_spi_si      (i_spi_si),
      .o_spi_so      (o_spi_so),
      .o_spi_so_en   (o_spi_so_en),
      .o_cmd         (o_cmd),
      .o_cmd_valid   (o_cmd_valid),
      .o_bad_cmd     (o_bad_cmd),
      .o_done        (o_done),
      .o_busy        (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   int n_valid, n_bad, n_done, n_en;
   bit exp_idle = 1'b0;
   logic [7:0] last_cmd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Frame-level model: a READ returns the temperature present at command time.
   function automatic logic [15:0] model_word(input logic [7:0] cmd, input logic [9:0] temp);
      return (cmd == 8'h03) ? {6'b0, temp} : 16'h0000;
   endfunction

   // Per-cycle monitor: pulse counting and output invariants.
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_cmd_valid) n_valid++;
         if (o_bad_cmd)   n_bad++;
         if (o_done)      n_done++;
         if (o_spi_so_en) n_en++;
         if (!o_spi_so_en) check("so_gated", {31'b0, o_spi_so}, 32'd0);
         if (exp_idle) begin
            check("idle_busy", {31'b0, o_busy}, 32'd0);
            check("idle_so_en", {31'b0, o_spi_so_en}, 32'd0);
         end
      end
   end

   // One initiator transaction. cmd_bits < 8 aborts early; chg_at / rst_at are
   // response-bit indices (or -1) after whose rising edge the temperature
   // changes or a one-cycle reset is applied.
   task automatic run_frame(input logic [7:0] cmd, input logic [9:0] temp,
                            input int cmd_bits, input int chg_at, input logic [9:0] chg_temp,
                            input int rst_at, output logic [15:0] word);
      int nbits;
      nbits = (cmd_bits < 8) ? cmd_bits : 24;
      word = '0;
      n_valid = 0; n_bad = 0; n_done = 0; n_en = 0;
      i_temperature = temp;
      exp_idle = 1'b0;
      i_spi_cs_n = 1'b0;
      tick(HALF);
      for (int b = 0; b < nbits; b++) begin
         i_spi_si = (b < 8) ? cmd[7-b] : 1'($urandom);
         tick(HALF);
         if (b >= 8) word = {word[14:0], o_spi_so};
         i_spi_clk = 1'b1;
         if (chg_at >= 0 && b - 8 == chg_at) i_temperature = chg_temp;
         if (rst_at >= 0 && b - 8 == rst_at) begin
            i_reset = 1'b1;
            tick(1);
            check("rst_so", {31'b0, o_spi_so}, 32'd0);
            check("rst_so_en", {31'b0, o_spi_so_en}, 32'd0);
            check("rst_cmd", {24'b0, o_cmd}, 32'd0);
            check("rst_busy", {31'b0, o_busy}, 32'd0);
            check("rst_pulses", {29'b0, o_cmd_valid, o_bad_cmd, o_done}, 32'd0);
            i_reset = 1'b0;
            exp_idle = 1'b1;
            tick(HALF - 1);
         end else begin
            tick(HALF);
         end
         i_spi_clk = 1'b0;
      end
      tick(HALF);
      i_spi_cs_n = 1'b1;
      i_spi_si = 1'b0;
      tick(6);
      exp_idle = 1'b1;
      tick(4 * HALF);
   endtask

   task automatic frame_check(input string tag, input logic [15:0] got, input logic [15:0] exp_w,
                              input int ev, input int eb, input int ed, input logic [7:0] ecmd,
                              input bit een);
      check({tag, "_word"}, {16'b0, got}, {16'b0, exp_w});
      check({tag, "_valid_cnt"}, n_valid, ev);
      check({tag, "_bad_cnt"}, n_bad, eb);
      check({tag, "_done_cnt"}, n_done, ed);
      check({tag, "_cmd"}, {24'b0, o_cmd}, {24'b0, ecmd});
      check({tag, "_so_en_seen"}, {31'b0, (n_en != 0)}, {31'b0, een});
   endtask

   initial begin
      logic [15:0] w;
      logic [7:0]  rc;
      logic [9:0]  rt, nt;
      int          ca;
      bit          is_rd;

      i_reset = 1'b1;
      i_temperature = 10'h000;
      i_spi_clk = 1'b0;
      i_spi_cs_n = 1'b1;
      i_spi_si = 1'b0;
      tick(3);
      check("reset_cmd", {24'b0, o_cmd}, 32'd0);
      check("reset_busy", {31'b0, o_busy}, 32'd0);
      check("reset_so", {30'b0, o_spi_so, o_spi_so_en}, 32'd0);
      check("reset_pulses", {29'b0, o_cmd_valid, o_bad_cmd, o_done}, 32'd0);
      i_reset = 1'b0;
      tick(10);
      exp_idle = 1'b1;

      // Basic read of 0x05A.
      run_frame(8'h03, 10'h05A, 8, -1, 10'h0, -1, w);
      frame_check("read_05a", w, 16'h005A, 1, 0, 1, 8'h03, 1'b1);

      // Unknown command: no drive, no done.
      run_frame(8'h9F, 10'h05A, 8, -1, 10'h0, -1, w);
      frame_check("bad_9f", w, 16'h0000, 1, 1, 0, 8'h9F, 1'b0);

      // Temperature changes after the 4th response bit: reply must not tear.
      run_frame(8'h03, 10'h05A, 8, 3, 10'h064, -1, w);
      frame_check("no_tear", w, 16'h005A, 1, 0, 1, 8'h03, 1'b1);
      run_frame(8'h03, 10'h064, 8, -1, 10'h0, -1, w);
      frame_check("read_064", w, 16'h0064, 1, 0, 1, 8'h03, 1'b1);

      // Aborted command after 5 bits, then a full-scale read.
      run_frame(8'h03, 10'h3FF, 5, -1, 10'h0, -1, w);
      frame_check("abort5", w, 16'h0000, 0, 0, 0, 8'h03, 1'b0);
      run_frame(8'h03, 10'h3FF, 8, -1, 10'h0, -1, w);
      frame_check("read_3ff", w, 16'h03FF, 1, 0, 1, 8'h03, 1'b1);

      // Reset during response bit 9, then a fresh read.
      run_frame(8'h03, 10'h05A, 8, -1, 10'h0, 9, w);
      check("rstmid_valid_cnt", n_valid, 1);
      check("rstmid_done_cnt", n_done, 0);
      check("rstmid_bad_cnt", n_bad, 0);
      check("rstmid_cmd", {24'b0, o_cmd}, 32'd0);
      run_frame(8'h03, 10'h1C3, 8, -1, 10'h0, -1, w);
      frame_check("after_rst", w, 16'h01C3, 1, 0, 1, 8'h03, 1'b1);
      last_cmd = 8'h03;

      // SCK activity with CS_n high is ignored.
      n_valid = 0; n_bad = 0; n_done = 0; n_en = 0;
      for (int k = 0; k < 20; k++) begin
         i_spi_si = 1'($urandom);
         i_spi_clk = 1'b1;
         tick(4);
         i_spi_clk = 1'b0;
         tick(4);
      end
      check("cs_high_pulses", n_valid + n_bad + n_done + n_en, 0);
      check("cs_high_cmd", {24'b0, o_cmd}, {24'b0, last_cmd});

      // Randomized frames against the model.
      for (int i = 0; i < 12; i++) begin
         is_rd = 1'($urandom_range(0, 1));
         rc = is_rd ? 8'h03 : 8'($urandom);
         rt = 10'($urandom);
         nt = 10'($urandom);
         ca = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 15)) : -1;
         run_frame(rc, rt, 8, ca, nt, -1, w);
         frame_check("rand", w, model_word(rc, rt), 1, (rc != 8'h03) ? 1 : 0,
                     (rc == 8'h03) ? 1 : 0, rc, rc == 8'h03);
         last_cmd = rc;
         tick(int'($urandom_range(0, 20)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
